// File: rtl/riscv_mdu_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mdu_pkg
// Shared definitions for the RV32M multiply/divide unit:
//   - RV32M instruction-class constants (opcode / funct7)
//   - mdu_op_e    : funct3 -> operation mapping
//   - mdu_state_e : control FSM states
// -----------------------------------------------------------------------------
package riscv_mdu_pkg;

  localparam logic [6:0] RV32M_OPCODE = 7'b0110011;
  localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/riscv_mdu_if.sv
// -----------------------------------------------------------------------------
// riscv_mdu_if
// Request/response bundle between the EX stage (master) and the MDU (slave).
//   start  : request, sampled when the unit can accept
//   funct3 : RV32M operation select
//   op_a   : rs1 operand        op_b : rs2 operand
//   flush  : abort in-flight operation
//   busy   : operation in progress (hold EX)
//   done   : one-cycle completion pulse
//   result : final value, held until replaced
// -----------------------------------------------------------------------------
interface riscv_mdu_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/riscv_mdu.sv
// -----------------------------------------------------------------------------
// riscv_mdu
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
// for any even DATA_W >= 8. Works on operand magnitudes for DATA_W CALC cycles
// (shift-add multiply or restoring divide), then applies sign correction and
// hi/lo selection in FIX. Divide-by-zero and signed overflow complete in one
// cycle without raising busy.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   mdu   : riscv_mdu_if slave modport (start/funct3/op_a/op_b/flush in,
//           busy/done/result out)
// -----------------------------------------------------------------------------
module riscv_mdu
  import riscv_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  riscv_mdu_if.slave mdu
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  mdu_state_e          state_q, state_d;
  mdu_op_e             op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W:0]     hi_q, hi_d;     // product high half / partial remainder
  logic [DATA_W-1:0]   lo_q, lo_d;     // multiplier->product low / dividend->quotient
  logic [DATA_W-1:0]   b_q, b_d;       // multiplicand / divisor magnitude
  logic                neg_q, neg_d;   // negate the selected result in FIX
  logic [DATA_W-1:0]   result_q, result_d;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in the cycle a start is accepted)
  // ---------------------------------------------------------------------------
  mdu_op_e           op_in;
  logic              is_div_in, is_rem_in, a_signed, b_signed, sign_a, sign_b;
  logic              div_zero, div_ovf, accept;
  logic [DATA_W-1:0] mag_a, mag_b, fast_res;

  assign op_in     = mdu_op_e'(mdu.funct3);
  assign is_div_in = mdu.funct3[2];
  assign is_rem_in = mdu.funct3[2] & mdu.funct3[1];
  assign a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                     (op_in == OP_DIV)  || (op_in == OP_REM);
  assign b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign sign_a    = a_signed & mdu.op_a[DATA_W-1];
  assign sign_b    = b_signed & mdu.op_b[DATA_W-1];
  // Most-negative input negates to itself, which is its correct unsigned magnitude.
  assign mag_a     = sign_a ? -mdu.op_a : mdu.op_a;
  assign mag_b     = sign_b ? -mdu.op_b : mdu.op_b;

  assign div_zero  = is_div_in & (mdu.op_b == '0);
  assign div_ovf   = is_div_in & a_signed & (mdu.op_a == MOST_NEG) & (&mdu.op_b);
  assign fast_res  = div_zero ? (is_rem_in ? mdu.op_a : '1)
                              : (is_rem_in ? '0 : mdu.op_a);

  assign accept    = mdu.start & ~mdu.flush &
                     ((state_q == S_IDLE) || (state_q == S_DONE));

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic                calc_div;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W+1:0]   div_shift, div_trial;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign calc_div  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign mul_sum   = hi_q + {1'b0, (lo_q[0] ? b_q : '0)};
  assign div_shift = {hi_q, lo_q[DATA_W-1]};
  assign div_trial = div_shift - {2'b00, b_q};

  assign prod      = {hi_q[DATA_W-1:0], lo_q};
  assign prod_fix  = neg_q ? -prod : prod;
  assign quo_fix   = neg_q ? -lo_q : lo_q;
  assign rem_fix   = neg_q ? -hi_q[DATA_W-1:0] : hi_q[DATA_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves it unassigned
    // and no latch is inferred.
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d  = op_in;
          neg_d = is_rem_in ? sign_a : (sign_a ^ sign_b);
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = fast_res;
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_W'(DATA_W - 1);
            hi_d    = '0;
            lo_d    = mag_a;
            b_d     = mag_b;
          end
        end
      end

      S_CALC: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          if (calc_div) begin
            // Restoring step: keep the subtraction only if it did not go negative.
            if (!div_trial[DATA_W+1]) begin
              hi_d = div_trial[DATA_W:0];
              lo_d = {lo_q[DATA_W-2:0], 1'b1};
            end else begin
              hi_d = div_shift[DATA_W:0];
              lo_d = {lo_q[DATA_W-2:0], 1'b0};
            end
          end else begin
            // Shift-add step: the consumed multiplier bit leaves lo_q as the
            // newest product bit enters from the top.
            hi_d = {1'b0, mul_sum[DATA_W:1]};
            lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:                        result_d = prod_fix[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*DATA_W-1:DATA_W];
            OP_DIV, OP_DIVU:               result_d = quo_fix;
            default:                       result_d = rem_fix;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: every register, datapath included, is reset so a reset mid-operation
  // leaves no stale value visible on result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign mdu.busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign mdu.done   = (state_q == S_DONE);
  assign mdu.result = result_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// -----------------------------------------------------------------------------
// tb_riscv_mdu
// Directed-vector bench for riscv_mdu (DATA_W=32). Cycle 0 is the cycle in
// which start is presented; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_riscv_mdu;
  import riscv_mdu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  riscv_mdu_if #(.DATA_W(32)) mdu_if ();

  riscv_mdu #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .mdu   (mdu_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one request in the current cycle (caller is at a falling edge),
  // then scrambles the inputs and waits for done. Leaves the bench at the
  // falling edge of the done cycle so a back-to-back start can follow.
  task automatic do_op(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_cyc);
    int   done_cyc     = -1;
    int   busy_cnt     = 0;
    logic busy_at_done = 1'b1;
    mdu_if.start  = 1'b1;
    mdu_if.funct3 = f3;
    mdu_if.op_a   = a;
    mdu_if.op_b   = b;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      mdu_if.start  = 1'b0;
      mdu_if.funct3 = ~f3;
      mdu_if.op_a   = ~a;
      mdu_if.op_b   = a ^ b ^ 32'h1234_5678;
      if (mdu_if.done) begin
        done_cyc     = cyc;
        busy_at_done = mdu_if.busy;
        break;
      end
      if (mdu_if.busy) busy_cnt++;
    end
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check({tag, "_busy_cycles"}, busy_cnt, exp_cyc - 1);
    check({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
    check({tag, "_result"}, mdu_if.result, exp);
  endtask

  initial begin
    int done_seen;
    mdu_if.start  = 1'b0;
    mdu_if.funct3 = 3'b000;
    mdu_if.op_a   = '0;
    mdu_if.op_b   = '0;
    mdu_if.flush  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, mdu_if.busy}, 32'd0);
    check("reset_done",   {31'd0, mdu_if.done}, 32'd0);
    check("reset_result", mdu_if.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply
    do_op("mul_7_m3",      OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34); @(negedge clk);
    do_op("mulh_min_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34); @(negedge clk);
    do_op("mulhu_min_min", OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34); @(negedge clk);
    do_op("mulhsu_m1_max", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34); @(negedge clk);
    do_op("mulhu_max_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34); @(negedge clk);
    do_op("mulh_m1_2",     OP_MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34); @(negedge clk);

    // Divide
    do_op("div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34); @(negedge clk);
    do_op("rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34); @(negedge clk);
    do_op("div_7_m2",      OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34); @(negedge clk);
    do_op("rem_7_m2",      OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34); @(negedge clk);
    // Back-to-back: REMU is started in the DONE cycle of DIVU.
    do_op("divu_100_7",    OP_DIVU,   32'd100,       32'd7,         32'd14,        34);
    do_op("remu_100_7_b2b", OP_REMU,  32'd100,       32'd7,         32'd2,         34); @(negedge clk);

    // Fast paths
    do_op("divu_5_0",      OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1); @(negedge clk);
    do_op("remu_5_0",      OP_REMU,   32'd5,         32'd0,         32'd5,         1); @(negedge clk);
    do_op("div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); @(negedge clk);
    do_op("rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1); @(negedge clk);
    do_op("div_5_0",       OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1); @(negedge clk);

    // Flush in cycle 10 of a DIV
    mdu_if.start  = 1'b1;
    mdu_if.funct3 = OP_DIV;
    mdu_if.op_a   = 32'd100;
    mdu_if.op_b   = 32'd7;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      mdu_if.start = 1'b0;
    end
    check("flush_busy_before", {31'd0, mdu_if.busy}, 32'd1);
    mdu_if.flush = 1'b1;
    @(negedge clk);
    mdu_if.flush = 1'b0;
    check("flush_busy_after", {31'd0, mdu_if.busy}, 32'd0);
    done_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (mdu_if.done) done_seen++;
      @(negedge clk);
    end
    check("flush_no_done", done_seen, 0);
    check("flush_result_kept", mdu_if.result, 32'hFFFF_FFFF);
    do_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, 34); @(negedge clk);

    // Flush together with start while idle suppresses the start
    mdu_if.start  = 1'b1;
    mdu_if.flush  = 1'b1;
    mdu_if.funct3 = OP_MUL;
    mdu_if.op_a   = 32'd5;
    mdu_if.op_b   = 32'd6;
    @(negedge clk);
    mdu_if.start = 1'b0;
    mdu_if.flush = 1'b0;
    check("flush_start_busy", {31'd0, mdu_if.busy}, 32'd0);
    check("flush_start_done", {31'd0, mdu_if.done}, 32'd0);
    @(negedge clk);
    check("flush_start_busy2", {31'd0, mdu_if.busy}, 32'd0);
    check("flush_start_result", mdu_if.result, 32'd12);

    // Reset mid-CALC
    mdu_if.start  = 1'b1;
    mdu_if.funct3 = OP_MUL;
    mdu_if.op_a   = 32'h0000_FFFF;
    mdu_if.op_b   = 32'h0000_FFFF;
    @(negedge clk);
    mdu_if.start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, mdu_if.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy",   {31'd0, mdu_if.busy}, 32'd0);
    check("rst_mid_done",   {31'd0, mdu_if.done}, 32'd0);
    check("rst_mid_result", mdu_if.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (mdu_if.done) done_seen++;
    end
    check("rst_mid_no_done", done_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
